// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a circular transmit FIFO.
// Frames are start, DATA_BITS LSB first, optional parity, STOP_BITS stops; consecutive frames abut.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_BITS-1:0]        data,
    input  logic                        valid,
    output logic                        ready,
    output logic                        txd,
    output logic                        is_send,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_r;
    logic [AW:0]          rd_ptr_r;
    logic [2:0]           state_r;
    logic [CW-1:0]        cnt_r;
    logic [IW-1:0]        idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 par_r;
    logic                 txd_r;
    logic                 is_send_r;

    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 bit_end_s;
    logic                 frame_end_s;
    logic [DATA_BITS-1:0] head_s;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~(^d);
        end else begin
            return ^d;
        end
    endfunction

    assign full_s      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign ready       = rst_n && !full_s;
    assign push_s      = valid && ready;
    assign bit_end_s   = (cnt_r == CNT_LAST);
    assign frame_end_s = (state_r == S_STOP) && bit_end_s && (stop_idx_r == STOP_LAST);
    // Reload happens from IDLE or straight out of the last stop cycle, so frames never leave a gap.
    assign pop_s       = !empty_s && ((state_r == S_IDLE) || frame_end_s);
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
    assign level       = wr_ptr_r - rd_ptr_r;
    assign txd         = txd_r;
    assign is_send     = is_send_r;

    // FIFO pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data;
        end
    end

    // Frame sequencer: txd only changes on bit boundaries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            idx_r      <= '0;
            stop_idx_r <= 1'b0;
            shreg_r    <= '0;
            par_r      <= 1'b0;
            txd_r      <= 1'b1;
            is_send_r  <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) || bit_end_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            case (state_r)
                S_IDLE: begin
                    txd_r     <= 1'b1;
                    is_send_r <= 1'b0;
                end
                S_START: begin
                    if (bit_end_s) begin
                        state_r <= S_DATA;
                        idx_r   <= '0;
                        txd_r   <= shreg_r[0];
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        if (idx_r == IDX_LAST) begin
                            if (PARITY != 0) begin
                                state_r <= S_PARITY;
                                txd_r   <= par_r;
                            end else begin
                                state_r    <= S_STOP;
                                stop_idx_r <= 1'b0;
                                txd_r      <= 1'b1;
                            end
                        end else begin
                            idx_r   <= idx_r + IDX_ONE;
                            shreg_r <= shreg_r >> 1;
                            txd_r   <= shreg_r[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_s) begin
                        state_r    <= S_STOP;
                        stop_idx_r <= 1'b0;
                        txd_r      <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        if (stop_idx_r != STOP_LAST) begin
                            stop_idx_r <= stop_idx_r + 1'b1;
                        end else if (!pop_s) begin
                            state_r   <= S_IDLE;
                            txd_r     <= 1'b1;
                            is_send_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    txd_r     <= 1'b1;
                    is_send_r <= 1'b0;
                end
            endcase
            // A pop overrides whatever the current state decided: load the next word and start.
            if (pop_s) begin
                shreg_r   <= head_s;
                par_r     <= parity_bit(head_s);
                state_r   <= S_START;
                txd_r     <= 1'b0;
                is_send_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a cycle-level frame/queue model checks the default instance;
// two 8-clock parity instances are checked against directly built frames.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] d0_data, dp_data, dq_data;
    logic       d0_valid, dp_valid, dq_valid;
    logic       d0_ready, dp_ready, dq_ready;
    logic       d0_txd, dp_txd, dq_txd;
    logic       d0_is_send, dp_is_send, dq_is_send;
    logic [2:0] d0_level, dp_level, dq_level;

    int vectors = 0;
    int miscompares = 0;

    // Reference model of the default instance: queued words plus the frame on the line.
    logic [7:0] m_q[$];
    logic       m_busy;
    int         m_cyc;
    logic [7:0] m_word;
    logic       m_acc;

    uart_tx_fifo u_d0 (
        .clk(clk), .rst_n(rst_n), .data(d0_data), .valid(d0_valid), .ready(d0_ready),
        .txd(d0_txd), .is_send(d0_is_send), .level(d0_level)
    );
    uart_tx_fifo #(.CLKS_PER_BIT(8), .PARITY(2)) u_dp (
        .clk(clk), .rst_n(rst_n), .data(dp_data), .valid(dp_valid), .ready(dp_ready),
        .txd(dp_txd), .is_send(dp_is_send), .level(dp_level)
    );
    uart_tx_fifo #(.CLKS_PER_BIT(8), .PARITY(1), .STOP_BITS(2)) u_dq (
        .clk(clk), .rst_n(rst_n), .data(dq_data), .valid(dq_valid), .ready(dq_ready),
        .txd(dq_txd), .is_send(dq_is_send), .level(dq_level)
    );

    // One clock: advance the model at the rising edge, return at the falling edge.
    task automatic step();
        @(posedge clk);
        m_acc = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_busy = 1'b0;
            m_cyc  = 0;
        end else begin
            m_acc = d0_valid && (m_q.size() < 4);
            if (m_busy) begin
                if (m_cyc == 39) m_busy = 1'b0;
                else m_cyc++;
            end
            if (!m_busy && m_q.size() != 0) begin
                m_word = m_q.pop_front();
                m_busy = 1'b1;
                m_cyc  = 0;
            end
            if (m_acc) m_q.push_back(d0_data);
        end
        @(negedge clk);
    endtask

    // Expected {txd, is_send, level, ready}: 8N1 frame of 10 bits, 4 clocks each.
    function automatic logic [5:0] m_exp();
        int   b;
        logic t;
        b = m_cyc / 4;
        if (!m_busy) t = 1'b1;
        else if (b == 0) t = 1'b0;
        else if (b <= 8) t = m_word[b-1];
        else t = 1'b1;
        return {t, m_busy, 3'(m_q.size()), rst_n && (m_q.size() < 4)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        d0_valid = 1'b0; dp_valid = 1'b0; dq_valid = 1'b0;
        d0_data = 8'h00; dp_data = 8'h00; dq_data = 8'h00;
        m_busy = 1'b0; m_cyc = 0; m_word = 8'h00; m_acc = 1'b0;
        step();
        step();
        vectors++;
        if ({d0_txd, d0_is_send, d0_level, d0_ready} !== 6'b1_0_000_0) begin
            miscompares++;
            $display("FAIL reset_d0: got %b expected %b", {d0_txd, d0_is_send, d0_level, d0_ready}, 6'b1_0_000_0);
        end
        vectors++;
        if ({dp_txd, dp_is_send, dp_level, dp_ready, dq_txd, dq_is_send, dq_level, dq_ready} !== 12'b1_0_000_0_1_0_000_0) begin
            miscompares++;
            $display("FAIL reset_parity_duts: got %b", {dp_txd, dp_is_send, dp_level, dp_ready, dq_txd, dq_is_send, dq_level, dq_ready});
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if ({d0_txd, d0_is_send, d0_level, d0_ready, dp_ready, dq_ready} !== 8'b1_0_000_1_1_1) begin
            miscompares++;
            $display("FAIL after_reset: got %b expected %b", {d0_txd, d0_is_send, d0_level, d0_ready, dp_ready, dq_ready}, 8'b1_0_000_1_1_1);
        end
    endtask

    task automatic test_single();
        int hi = 0;
        for (int c = 0; c < 50; c++) begin
            d0_valid = (c == 0);
            d0_data  = 8'hA5;
            step();
            vectors++;
            if ({d0_txd, d0_is_send, d0_level, d0_ready} !== m_exp()) begin
                miscompares++;
                $display("FAIL single c%0d: got %b expected %b", c, {d0_txd, d0_is_send, d0_level, d0_ready}, m_exp());
            end
            if (d0_is_send) hi++;
        end
        vectors++;
        if (hi !== 40 || d0_level !== 3'd0) begin
            miscompares++;
            $display("FAIL single_len: is_send cycles %0d level %0d, expected 40 and 0", hi, d0_level);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w[3] = '{8'h11, 8'h22, 8'h33};
        int   hi = 0;
        int   rises = 0;
        logic prev = 1'b0;
        for (int c = 0; c < 130; c++) begin
            d0_valid = (c < 3);
            d0_data  = w[(c < 3) ? c : 0];
            step();
            vectors++;
            if ({d0_txd, d0_is_send, d0_level, d0_ready} !== m_exp()) begin
                miscompares++;
                $display("FAIL b2b c%0d: got %b expected %b", c, {d0_txd, d0_is_send, d0_level, d0_ready}, m_exp());
            end
            if (d0_is_send) hi++;
            if (d0_is_send && !prev) rises++;
            prev = d0_is_send;
        end
        vectors++;
        if (hi !== 120 || rises !== 1) begin
            miscompares++;
            $display("FAIL b2b_is_send: high %0d rises %0d, expected 120 and 1", hi, rises);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] nxt = 8'h40;
        int acc = 0;
        int edge6 = 0;
        logic drop_seen = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            logic go;
            d0_valid = (acc < 8);
            d0_data  = nxt;
            go = d0_valid && d0_ready;
            step();
            if (go) begin
                acc++;
                nxt++;
                if (acc == 6) edge6 = c;
            end
            vectors++;
            if ({d0_txd, d0_is_send, d0_level, d0_ready} !== m_exp()) begin
                miscompares++;
                $display("FAIL backpressure c%0d: got %b expected %b", c, {d0_txd, d0_is_send, d0_level, d0_ready}, m_exp());
            end
            if (!drop_seen && !d0_ready) begin
                drop_seen = 1'b1;
                vectors++;
                if (acc !== 5 || d0_level !== 3'd4) begin
                    miscompares++;
                    $display("FAIL bp_full: accepted %0d level %0d, expected 5 and 4", acc, d0_level);
                end
            end
            if (acc == 8 && !m_busy && m_q.size() == 0) break;
        end
        // First push at edge 1, frame occupies edges 2..42, so the 6th word lands at edge 43.
        vectors++;
        if (edge6 !== 43 || !drop_seen) begin
            miscompares++;
            $display("FAIL bp_sixth: accepted at edge %0d drop_seen %0b, expected 43 and 1", edge6, drop_seen);
        end
        vectors++;
        if (acc !== 8 || m_busy) begin
            miscompares++;
            $display("FAIL bp_drain: accepted %0d busy %0b, expected 8 and 0", acc, m_busy);
        end
    endtask

    task automatic test_wrap();
        int acc = 0;
        int gap = 0;
        logic [7:0] w = 8'($urandom);
        for (int c = 0; c < 5000; c++) begin
            logic go;
            d0_valid = (acc < 20) && (gap == 0);
            d0_data  = w;
            go = d0_valid && d0_ready;
            step();
            if (go) begin
                acc++;
                w = 8'($urandom);
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 90) : $urandom_range(0, 4);
            end else if (gap > 0) begin
                gap--;
            end
            vectors++;
            if ({d0_txd, d0_is_send, d0_level, d0_ready} !== m_exp() || d0_level > 3'd4) begin
                miscompares++;
                $display("FAIL wrap c%0d: got %b expected %b", c, {d0_txd, d0_is_send, d0_level, d0_ready}, m_exp());
            end
            if (acc == 20 && !m_busy && m_q.size() == 0) break;
        end
        vectors++;
        if (acc !== 20 || m_busy) begin
            miscompares++;
            $display("FAIL wrap_drain: accepted %0d busy %0b, expected 20 and 0", acc, m_busy);
        end
    endtask

    task automatic test_reset_mid();
        int hi = 0;
        for (int c = 0; c < 40; c++) begin
            d0_valid = (c < 3);
            d0_data  = 8'hC0 + 8'(c);
            step();
            vectors++;
            if ({d0_txd, d0_is_send, d0_level, d0_ready} !== m_exp()) begin
                miscompares++;
                $display("FAIL rmid_pre c%0d: got %b expected %b", c, {d0_txd, d0_is_send, d0_level, d0_ready}, m_exp());
            end
            if (m_busy && m_cyc == 12) break;
        end
        rst_n = 1'b0;
        d0_valid = 1'b0;
        step();
        vectors++;
        if ({d0_txd, d0_is_send, d0_level, d0_ready} !== 6'b1_0_000_0) begin
            miscompares++;
            $display("FAIL rmid_reset: got %b expected %b", {d0_txd, d0_is_send, d0_level, d0_ready}, 6'b1_0_000_0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 110; c++) begin
            d0_valid = (c == 60);
            d0_data  = 8'h3C;
            step();
            vectors++;
            if ({d0_txd, d0_is_send, d0_level, d0_ready} !== m_exp()) begin
                miscompares++;
                $display("FAIL rmid_post c%0d: got %b expected %b", c, {d0_txd, d0_is_send, d0_level, d0_ready}, m_exp());
            end
            if (d0_is_send) hi++;
        end
        vectors++;
        if (hi !== 40) begin
            miscompares++;
            $display("FAIL rmid_len: is_send cycles %0d, expected 40", hi);
        end
    endtask

    task automatic test_parity();
        for (int k = 0; k < 2; k++) begin
            logic [7:0] w;
            logic eb [12];
            logic ob [12];
            int hie = 0;
            int hio = 0;
            logic te, to;
            w = (k == 0) ? 8'h07 : 8'($urandom);
            eb[0] = 1'b0;
            ob[0] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                eb[i+1] = w[i];
                ob[i+1] = w[i];
            end
            eb[9]  = ($countones(w) % 2 == 1);
            ob[9]  = ($countones(w) % 2 == 0);
            eb[10] = 1'b1; eb[11] = 1'b1;
            ob[10] = 1'b1; ob[11] = 1'b1;
            dp_valid = 1'b1; dq_valid = 1'b1;
            dp_data  = w;    dq_data  = w;
            step();
            dp_valid = 1'b0; dq_valid = 1'b0;
            vectors++;
            if (dp_level !== 3'd1 || dq_level !== 3'd1) begin
                miscompares++;
                $display("FAIL parity_push: levels %0d %0d, expected 1 1", dp_level, dq_level);
            end
            for (int c = 1; c <= 110; c++) begin
                step();
                te = (c <= 88) ? eb[(c-1)/8] : 1'b1;
                to = (c <= 96) ? ob[(c-1)/8] : 1'b1;
                vectors++;
                if ({dp_txd, dp_is_send, dq_txd, dq_is_send} !== {te, 1'(c <= 88), to, 1'(c <= 96)}) begin
                    miscompares++;
                    $display("FAIL parity w%02h c%0d: got %b expected %b", w, c,
                             {dp_txd, dp_is_send, dq_txd, dq_is_send}, {te, 1'(c <= 88), to, 1'(c <= 96)});
                end
                if (dp_is_send) hie++;
                if (dq_is_send) hio++;
            end
            vectors++;
            if (hie !== 88 || hio !== 96) begin
                miscompares++;
                $display("FAIL parity_len: even %0d odd2stop %0d, expected 88 96", hie, hio);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO. It serialises words from a valid/ready write port and supports configurable bit period, data width, parity and stop bits. Back-to-back frames go out with no idle gap. It sits between the core's I/O store path and the TX pin, and replaces the fixed 8N1, 4-clocks-per-bit, single-buffer sender.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; ≥2.
- DATA_BITS, 8: payload bits per frame; 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- data  in  DATA_BITS  word to transmit.
- valid  in  1  data is offered this cycle.
- ready  out  1  FIFO can accept a word; equals !full; forced 0 while rst_n=0.
- txd  out  1  serial line, idle high; registered.
- is_send  out  1  a frame is on the line; registered.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the word in the shifter.

## Operation
- **Push rule:** a word is pushed when valid && ready at a rising edge. With valid=1 and ready=0 nothing is written and nothing is lost. The sender holds data stable until accepted.
- **Frame order:** start bit (0), then DATA_BITS payload bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1).
- **Parity:**
  - Odd: payload plus parity bit contains an odd number of ones.
  - Even: it contains an even number of ones.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1, is_send=0. If level≠0, pop the FIFO head into the shift register and go to START.
  - Every non-IDLE state holds its bit for exactly CLKS_PER_BIT cycles, timed by a $clog2(CLKS_PER_BIT)-bit counter.
  - START → DATA.
  - DATA repeats DATA_BITS times, using a bit index counter. Then it goes to PARITY if PARITY≠0, else to STOP.
  - PARITY → STOP.
  - STOP repeats STOP_BITS times.
  - On the last cycle of the last stop bit: if level≠0, pop and go directly to START. Otherwise go to IDLE.
- **Frame length:** CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- **is_send:** 1 from the first START cycle through the last stop cycle. It stays 1 continuously across back-to-back frames.
- **FIFO:** circular, with read/write pointers one bit wider than the index. Both pointers wrap modulo 2·FIFO_DEPTH.
  - Full when the indices are equal and the MSBs differ.
  - Empty when the pointers are equal.
- **Simultaneous push and pop:**
  - Allowed when not full; level is unchanged.
  - When full, ready=0 even if a pop happens in the same cycle. No combinational ready-from-pop path.
  - When empty, no pop is possible, so a push simply increments level.
- **Reset** (rst_n=0 at an edge), including mid-frame:
  - FSM → IDLE, txd=1, is_send=0, level=0, pointers=0.
  - FIFO contents are discarded and the partial frame is abandoned.

## Timing
- **Reset values:** txd=1, is_send=0, level=0, ready=0 during reset, ready=1 on the first cycle after reset.
- **Latency:** push accepted at edge k → level=1 after k. At edge k+1 the FSM pops, so txd=0 and is_send=1 after k+1. Push-to-start-bit latency is 1 cycle.
- **txd** changes only at bit boundaries, never mid-bit. There is no glitch, because the output is registered.
- **No gap between frames:** the last stop cycle of frame n is immediately followed by the first start cycle of frame n+1.
- **Capacity:** FIFO_DEPTH words queued plus 1 in the shifter.

## Test plan
- **Single byte, defaults** (4 clk/bit, 8N1): push 0xA5 → txd = 0,1,0,1,0,0,1,0,1,1. Each level is held 4 cycles; is_send is high for exactly 40 cycles; level returns to 0.
- **Parity**, DATA_BITS=8, PARITY=2, CLKS_PER_BIT=8:
  - Push 0x07 → parity bit 1, frame 88 cycles.
  - Same with PARITY=1 → parity bit 0.
  - STOP_BITS=2 with PARITY=0 → 2 stop bits, frame 88 cycles.
- **Back-to-back:** push 0x11, 0x22, 0x33 on consecutive cycles → is_send high for 120 cycles with no dip, and the three frames arrive in order.
- **Backpressure:** hold valid=1 with incrementing data from idle, with FIFO_DEPTH=4.
  - 5 words are accepted (1 in shifter, 4 in FIFO); ready drops with level=4.
  - The 6th word is accepted only after the first frame ends.
  - All words are transmitted exactly once, in order.
- **Pointer wrap:** push 20 words at random gaps → output order is preserved and level never exceeds 4.
- **Reset mid-frame:** assert rst_n=0 for 1 cycle during DATA of frame 1, with 2 words queued.
  - After that edge: txd=1, is_send=0, level=0.
  - No further frames.
  - A new push afterwards transmits normally.
